simple_issue: RTL
=================

Name: simple_issue

Overview:
Issue stage directly downstream of the simple-instruction fetch stage; it is the consumer side of the fetch/issue interface.
- Accepts instructions via INSTRV/DEC_INSTR and applies back-pressure with ISSUE_BUSY.
- Buffers accepted instructions in an in-order queue and decodes register fields.
- Holds each instruction back on register hazards, tracked by a scoreboard that write-back clears.
- Hands instructions to the execute unit over a valid/ready handshake.

Parameters:
DEPTH, 4, instruction queue entries; power of two, >=2
PTR_W, 2, log2(DEPTH); queue pointer width

Ports:
CLK  input  1  clock; all state updates on posedge
RSTN  input  1  asynchronous active-low reset
INSTRV  input  1  fetch presents a valid instruction
DEC_INSTR  input  32  instruction word from fetch
ISSUE_BUSY  output  1  back-pressure to fetch; 1 = no accept this cycle
EX_VALID  output  1  head instruction is issuable
EX_OPCODE  output  6  head DEC_INSTR[31:26]
EX_RD  output  5  head DEC_INSTR[25:21]
EX_RS1  output  5  head DEC_INSTR[20:16]
EX_RS2  output  5  head DEC_INSTR[15:11]
EX_IMM  output  16  head DEC_INSTR[15:0]
EX_READY  input  1  execute unit accepts this cycle
WB_VALID  input  1  write-back completes a register write
WB_RD  input  5  register written back

Behaviour:
Clock and reset:
- One clock, CLK. Reset is asynchronous and active-low on RSTN.

Reset:
- Queue pointers, count, entries and all 32 scoreboard bits clear to 0.
- Outputs during and after reset: ISSUE_BUSY=0, EX_VALID=0, all EX_* fields 0.
- Reset asserted mid-operation drops all queued instructions and scoreboard state immediately. No transfer is reported on either side in that cycle.

Accept (fetch side):
- ISSUE_BUSY = (count == DEPTH). It is decoded from registered count only, so there is no combinational path from any input.
- A push occurs at posedge when INSTRV=1 and ISSUE_BUSY=0. DEC_INSTR is written at the tail and the tail increments (wraps modulo DEPTH).
- INSTRV=1 while ISSUE_BUSY=1: nothing is written. Fetch holds INSTRV and DEC_INSTR stable until accepted.
- No full-bypass: when full, a same-cycle pop does not allow a push that cycle.

Hazard and issue:
- EX_* fields are decoded combinationally from the head entry, whether or not the queue is empty.
- hazard = sb[rs1] | sb[rs2] | sb[rd] (covers RAW and WAW). sb[0] is constant 0.
- The hazard check uses the registered scoreboard. A same-cycle WB clear is not bypassed and becomes visible the next cycle.
- EX_VALID = (count != 0) & ~hazard. EX_VALID does not depend on EX_READY.
- Issue occurs at posedge when EX_VALID=1 and EX_READY=1. The head pops and increments (wraps). If rd != 0, sb[rd] is set.
- Latency: an instruction pushed into an empty queue is presented on EX_VALID the following cycle, earliest.
- Issue is strictly in order; a stalled head blocks younger entries.

Scoreboard:
- WB_VALID=1 clears sb[WB_RD] at posedge. WB_RD=0 has no effect.
- Same cycle, same register, issue-set and WB-clear: set wins (the new producer is outstanding).

Count:
- push only: +1. Pop only: -1. Push and pop together: unchanged.
- count never exceeds DEPTH and never underflows.

Test Plan:
- Single issue: reset, EX_READY=1, push 32'h04611000 once -> next cycle EX_VALID=1, EX_OPCODE=6'h01, EX_RD=3, EX_RS1=1, EX_RS2=2, EX_IMM=16'h1000; after issue, sb[3]=1 and EX_VALID=0.
- RAW stall: push 32'h04611000 then 32'h04830000 (rd=4, rs1=3), EX_READY=1 -> second instruction held with EX_VALID=0. WB_VALID=1, WB_RD=3 at cycle N -> EX_VALID=1 at cycle N+1 (no bypass).
- Full queue: EX_READY=0, INSTRV=1 with 5 distinct words, DEPTH=4 -> ISSUE_BUSY=1 after the 4th push, 5th word not written. One pop -> ISSUE_BUSY=0 next cycle; 5th accepted in the following cycle.
- Pointer wrap and order: stream 10 independent instructions (rd=0), random EX_READY -> EX outputs issue in push order with none lost or duplicated; count stays within 0..4.
- Simultaneous set/clear: head writes rd=5 issuing in the same cycle as WB_VALID=1, WB_RD=5 -> sb[5]=1 afterwards; a following reader of r5 stalls.
- Reset mid-stream: assert RSTN=0 with 3 queued entries and sb[3]=1 -> ISSUE_BUSY=0, EX_VALID=0 and EX_* fields 0 immediately, without waiting for a clock edge; after release, the first push issues with no stale hazard.

Source files
------------

// File: rtl/simple_issue.sv
// rtl/simple_issue.sv - in-order issue queue with register scoreboard hazard check
// Consumer of the fetch/issue interface; hands decoded instructions to execute.
module simple_issue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        INSTRV,
   input  logic [31:0] DEC_INSTR,
   output logic        ISSUE_BUSY,
   output logic        EX_VALID,
   output logic [5:0]  EX_OPCODE,
   output logic [4:0]  EX_RD,
   output logic [4:0]  EX_RS1,
   output logic [4:0]  EX_RS2,
   output logic [15:0] EX_IMM,
   input  logic        EX_READY,
   input  logic        WB_VALID,
   input  logic [4:0]  WB_RD
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [31:0]      sb_q, sb_d;

   logic [31:0] head_instr;
   logic        hazard;
   logic        push;
   logic        pop;

   assign head_instr = mem_q[head_q];
   assign EX_OPCODE  = head_instr[31:26];
   assign EX_RD      = head_instr[25:21];
   assign EX_RS1     = head_instr[20:16];
   assign EX_RS2     = head_instr[15:11];
   assign EX_IMM     = head_instr[15:0];

   // Hazard uses the registered scoreboard only; write-back is never bypassed.
   assign hazard     = sb_q[EX_RS1] | sb_q[EX_RS2] | sb_q[EX_RD];
   assign ISSUE_BUSY = (count_q == FULL_CNT);
   assign EX_VALID   = (count_q != '0) & ~hazard;
   assign push       = INSTRV & ~ISSUE_BUSY;
   assign pop        = EX_VALID & EX_READY;

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      sb_d    = sb_q;

      if (push) begin
         mem_d[tail_q] = DEC_INSTR;
         tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase

      // Clear first so a same-cycle issue to the same register leaves it outstanding.
      if (WB_VALID) begin
         sb_d[WB_RD] = 1'b0;
      end
      if (pop) begin
         sb_d[EX_RD] = 1'b1;
      end
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         sb_q    <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         sb_q    <= sb_d;
      end
   end

endmodule
